// File: rtl/generic_pkg.sv
// generic_pkg: shared state encoding and channel-index width helper for the stream mux
package generic_pkg;

    typedef enum logic {IDLE, LOCKED} state_t;

    function automatic int cw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first requesting channel at/after ptr (mode 1) or from index 0 (mode 0)
module rr_priority_pick #(
    parameter int CH = 4,
    parameter int CW = 2
) (
    input  logic [CH-1:0] req,
    input  logic [CW-1:0] ptr,
    input  logic          mode,
    output logic          found,
    output logic [CW-1:0] idx
);
    int k;

    // scan from the far end down so the channel closest to the start point wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = CH - 1; i >= 0; i--) begin
            k = ((mode ? int'(ptr) : 0) + i) % CH;
            if (req[k]) begin
                found = 1'b1;
                idx   = CW'(k);
            end
        end
    end

endmodule

// File: rtl/generic_stream_mux.sv
// generic_stream_mux: packet-locked N:1 stream mux with registered output and valid/ready handshake
module generic_stream_mux
    import generic_pkg::*;
#(
    parameter int W  = 8,
    parameter int CH = 4,
    localparam int CW = cw_of(CH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            mode,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH-1:0]   in_last,
    output logic [CH-1:0]   in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic [CW-1:0]   out_chan,
    input  logic            out_ready
);
    state_t        state, state_nxt;
    logic [CW-1:0] grant, rr_ptr, pick, sel;
    logic          found, load, xfer, beat_last;
    logic [W-1:0]  beat_data;

    rr_priority_pick #(.CH(CH), .CW(CW)) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .mode  (mode),
        .found (found),
        .idx   (pick)
    );

    // arbitration, handshake and next state; in_ready is held low while reset is asserted
    always_comb begin
        sel       = (state == LOCKED) ? grant : pick;
        load      = ~out_valid | out_ready;
        xfer      = resetn & load & ((state == LOCKED) ? in_valid[grant] : found);
        beat_data = in_data[sel*W +: W];
        beat_last = in_last[sel];
        in_ready  = xfer ? (CH'(1) << sel) : '0;
        state_nxt = xfer ? (beat_last ? IDLE : LOCKED) : state;
    end

    // packet ownership state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // grant, round-robin pointer and output beat register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant     <= '0;
            rr_ptr    <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            if (state == IDLE && !beat_last) grant <= sel;
            if (beat_last) rr_ptr <= (sel == CW'(CH - 1)) ? '0 : sel + 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
            out_chan  <= sel;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_generic_stream_mux.sv
// tb_generic_stream_mux: randomized scoreboard bench against a packet-level arbitration model
module tb_generic_stream_mux;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic          last;
        logic [W-1:0]  data;
    } beat_t;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            mode = 1'b0;
    logic            out_ready = 1'b1;
    logic [CH*W-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic [CH-1:0]   in_last = '0;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [CW-1:0]   out_chan;

    beat_t      sb[$];
    logic [W:0] src[CH][$];
    int         checks = 0;
    int         passes = 0;
    int         owner = -1;
    int         rr = 0;
    int         vprob = 100;
    int         xfer_ch = -1;
    bit         m_ov = 1'b0;
    bit         hold = 1'b0;
    beat_t      got, exp_b, prev;

    always #5 clk = ~clk;

    generic_stream_mux #(.W(W), .CH(CH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // monitor: pops the scoreboard on each accepted output beat and checks stability under backpressure
    always @(negedge clk) begin
        got = {out_chan, out_last, out_data};
        if (!resetn) begin
            hold = 1'b0;
        end else begin
            if (hold) chk(out_valid && got == prev, "hold_stable", {out_valid, got}, {1'b1, prev});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_beat", got, 0);
                end else begin
                    exp_b = sb.pop_front();
                    chk(got == exp_b, "beat", got, exp_b);
                end
            end
            hold = out_valid && !out_ready;
            prev = got;
        end
    end

    // packet-level reference: who owns the output, who should be offered a beat this cycle
    task automatic model_cycle();
        int sel;
        int c;
        bit load;
        logic [CH-1:0] exp_rdy;
        sel = -1;
        if (owner >= 0) begin
            if (in_valid[owner]) sel = owner;
        end else begin
            for (int j = 0; j < CH; j++) begin
                c = mode ? (rr + j) % CH : j;
                if (in_valid[c] && sel < 0) sel = c;
            end
        end
        load = !m_ov || out_ready;
        exp_rdy = (load && sel >= 0) ? (CH'(1) << sel) : '0;
        chk(in_ready == exp_rdy, "in_ready", in_ready, exp_rdy);
        xfer_ch = -1;
        if (load && sel >= 0) begin
            sb.push_back({CW'(sel), in_last[sel], in_data[sel*W +: W]});
            if (in_last[sel]) begin
                owner = -1;
                rr = (sel + 1) % CH;
            end else begin
                owner = sel;
            end
            m_ov = 1'b1;
            xfer_ch = sel;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic drive();
        if (xfer_ch >= 0 && src[xfer_ch].size() > 0) void'(src[xfer_ch].pop_front());
        for (int k = 0; k < CH; k++) begin
            if (src[k].size() > 0) begin
                in_valid[k] = ($urandom_range(99) < vprob);
                {in_last[k], in_data[k*W +: W]} = src[k][0];
            end else begin
                in_valid[k] = 1'b0;
                in_last[k] = 1'b0;
                in_data[k*W +: W] = '0;
            end
        end
    endtask

    task automatic step(input int rp);
        @(negedge clk);
        #1;
        model_cycle();
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < rp);
        drive();
    endtask

    task automatic push_pkt(input int k, input int len, input int base);
        for (int b = 0; b < len; b++) src[k].push_back({b == len - 1, W'(base + b)});
    endtask

    task automatic clear_src();
        for (int k = 0; k < CH; k++) src[k].delete();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        in_valid = '1;
        out_ready = 1'b1;
        clear_src();
        sb.delete();
        owner = -1;
        rr = 0;
        m_ov = 1'b0;
        xfer_ch = -1;
        #2;
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(in_ready == '0, "rst_in_ready", in_ready, 0);
        chk(out_chan == '0, "rst_out_chan", out_chan, 0);
        chk(out_data == '0, "rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        chk(in_ready == '0, "rst_in_ready_hold", in_ready, 0);
        for (int k = 0; k < CH; k++) push_pkt(k, 1, 'hA0 + k);
        resetn = 1'b1;
        drive();
    endtask

    initial begin
        mode = 1'b0;
        apply_reset();
        repeat (6) step(100);
        // fixed priority: channel 1 always beats channel 3
        clear_src();
        mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_pkt(1, 1, 'h11);
            push_pkt(3, 1, 'h33);
        end
        repeat (16) step(100);
        clear_src();
        repeat (3) step(100);
        // round-robin over four continuous single-beat sources
        mode = 1'b1;
        for (int i = 0; i < 8; i++) for (int k = 0; k < CH; k++) push_pkt(k, 1, 'hA0 + k);
        repeat (20) step(100);
        clear_src();
        repeat (3) step(100);
        // packet lock: channel 2 owns the output while channel 0 waits
        mode = 1'b0;
        push_pkt(2, 3, 'h21);
        repeat (2) step(100);
        for (int i = 0; i < 4; i++) push_pkt(0, 1, 'h01 + i);
        repeat (8) step(100);
        // backpressure mid-packet
        mode = 1'b1;
        push_pkt(1, 6, 'h40);
        push_pkt(3, 2, 'h70);
        push_pkt(3, 2, 'h78);
        repeat (3) step(100);
        repeat (5) step(0);
        repeat (12) step(100);
        // randomized traffic, readiness and mode changes
        vprob = 70;
        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 0) mode = $urandom_range(1);
            for (int k = 0; k < CH; k++)
                if (src[k].size() < 2) push_pkt(k, $urandom_range(1, 4), $urandom_range(255));
            step(60);
        end
        vprob = 100;
        clear_src();
        repeat (4) step(100);
        // reset while channel 1 owns the output with rr pointer away from 0
        mode = 1'b1;
        push_pkt(2, 1, 'h2F);
        repeat (3) step(100);
        push_pkt(1, 4, 'h50);
        repeat (3) step(100);
        apply_reset();
        repeat (6) step(100);
        clear_src();
        for (int n = 0; n < 20 && sb.size() > 0; n++) step(100);
        chk(sb.size() == 0, "drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
